// File: rtl/pingpong_line_buffer_pkg.sv
// Shared constants and helpers for the ping-pong line buffer.
// Default geometry matches the thermal sensor readout path; the top
// module can be re-parameterised (e.g. short rows for bring-up).
package pingpong_line_buffer_pkg;

  // Default geometry.
  localparam int DEF_DATA_W      = 14;
  localparam int DEF_PIX_PER_ROW = 640;
  localparam int DEF_N_CH        = 2;
  localparam int DEF_ADDR_W      = 10;

  // Two banks, addressed by a single bank bit.
  localparam int NUM_BANKS  = 2;
  localparam int DROP_CNT_W = 8;

  // Index of the last pixel in a row of the given length.
  function automatic int last_pix_of(input int pix_per_row);
    return pix_per_row - 1;
  endfunction

  // Last pixel index for the default row length.
  localparam int LAST_PIX = last_pix_of(DEF_PIX_PER_ROW);

  // A bank holds a completed, unread row when its write-side and
  // read-side toggles disagree.
  function automatic logic [NUM_BANKS-1:0] banks_full(
    input logic [NUM_BANKS-1:0] wr_tog,
    input logic [NUM_BANKS-1:0] rd_tog
  );
    return wr_tog ^ rd_tog;
  endfunction

endpackage : pingpong_line_buffer_pkg

// File: rtl/pingpong_line_buffer_if.sv
// Bus interface of the ping-pong line buffer: ADC-side write port and
// frame-side read port. Clocks and reset stay outside the interface.
//
// Handshake semantics:
//   Write side (WR_CLK): there is no back-pressure. wr_valid marks one
//   pixel per cycle; wr_line_start marks the first cycle of a row and may
//   coincide with the first wr_valid. Rejected rows are reported through
//   wr_drop / wr_drop_cnt rather than stalled.
//   Read side (RD_CLK): rd_en is a request. When a completed row is
//   available the request is accepted and rd_valid is high exactly one
//   RD_CLK later with rd_data/rd_first/rd_last; when no row is available
//   the request is ignored and rd_valid stays low.
interface pingpong_line_buffer_if
  import pingpong_line_buffer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int N_CH   = DEF_N_CH
);

  // Write domain
  logic                   wr_line_start;
  logic                   wr_valid;
  logic [N_CH*DATA_W-1:0] wr_data;
  logic                   wr_drop;
  logic [DROP_CNT_W-1:0]  wr_drop_cnt;
  logic                   wr_overrun;

  // Read domain
  logic                   rd_en;
  logic                   rd_valid;
  logic [DATA_W-1:0]      rd_data;
  logic                   rd_first;
  logic                   rd_last;
  logic [1:0]             rd_lines_avail;

  // Producer/consumer side (ADC front end and frame logic).
  modport master (
    output wr_line_start, wr_valid, wr_data, rd_en,
    input  wr_drop, wr_drop_cnt, wr_overrun,
    input  rd_valid, rd_data, rd_first, rd_last, rd_lines_avail
  );

  // Line buffer side.
  modport slave (
    input  wr_line_start, wr_valid, wr_data, rd_en,
    output wr_drop, wr_drop_cnt, wr_overrun,
    output rd_valid, rd_data, rd_first, rd_last, rd_lines_avail
  );

endinterface : pingpong_line_buffer_if

// File: rtl/pingpong_line_buffer_sync_2ff.sv
// Two-flop synchroniser for slowly changing control bits (bank toggles,
// reset release). Each bit is synchronised independently; the toggles
// it carries change one bit at a time, so no bus coherency is needed.
module sync_2ff
  import pingpong_line_buffer_pkg::*;
#(
  parameter int W = NUM_BANKS
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  // Two capture stages, cleared asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule : sync_2ff

// File: rtl/pingpong_line_buffer.sv
// Dual-clock ping-pong line buffer. Rows from N_CH interleaved ADC
// channels are written into one of two banks in the WR_CLK domain and
// streamed out in the RD_CLK domain. Bank ownership passes through a
// pair of toggle bits per bank: the writer flips wr_tog[b] when bank b
// holds a complete row, the reader flips rd_tog[b] when it has drained
// it. Each side sees the other's toggles through a 2-flop synchroniser.
module pingpong_line_buffer
  import pingpong_line_buffer_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int PIX_PER_ROW = DEF_PIX_PER_ROW,
  parameter int N_CH        = DEF_N_CH,
  parameter int ADDR_W      = DEF_ADDR_W
) (
  input logic              WR_CLK,
  input logic              RD_CLK,
  input logic              RESET,
  pingpong_line_buffer_if.slave bus
);

  localparam int LAST  = last_pix_of(PIX_PER_ROW);
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  // RAM address is {bank, pixel}; with a power-of-two row length this is
  // exactly two rows of storage.
  localparam int DEPTH = 2 ** (ADDR_W + 1);

  // Write pointer has one extra bit so it can sit at PIX_PER_ROW after
  // a completed row (used to detect overrun pixels).
  localparam logic [ADDR_W:0]   WPTR_LAST = (ADDR_W + 1)'(LAST);
  localparam logic [ADDR_W:0]   WPTR_END  = (ADDR_W + 1)'(PIX_PER_ROW);
  localparam logic [ADDR_W-1:0] RPTR_LAST = ADDR_W'(LAST);

  // ------------------------------------------------------------------
  // Per-domain reset: asserts immediately with RESET, releases
  // synchronously to the local clock.
  // ------------------------------------------------------------------
  logic wr_rst_n;
  logic rd_rst_n;
  logic wr_rst;
  logic rd_rst;

  sync_2ff #(.W(1)) u_wr_rst_sync (
    .clk_i (WR_CLK),
    .rst_i (RESET),
    .d_i   (1'b1),
    .q_o   (wr_rst_n)
  );

  sync_2ff #(.W(1)) u_rd_rst_sync (
    .clk_i (RD_CLK),
    .rst_i (RESET),
    .d_i   (1'b1),
    .q_o   (rd_rst_n)
  );

  assign wr_rst = ~wr_rst_n;
  assign rd_rst = ~rd_rst_n;

  // ------------------------------------------------------------------
  // Toggle crossing
  // ------------------------------------------------------------------
  logic [NUM_BANKS-1:0] wr_tog_q;
  logic [NUM_BANKS-1:0] wr_tog_d;
  logic [NUM_BANKS-1:0] rd_tog_q;
  logic [NUM_BANKS-1:0] rd_tog_d;
  logic [NUM_BANKS-1:0] rd_tog_in_wr;  // rd_tog seen from WR_CLK
  logic [NUM_BANKS-1:0] wr_tog_in_rd;  // wr_tog seen from RD_CLK

  sync_2ff #(.W(NUM_BANKS)) u_rd2wr_tog_sync (
    .clk_i (WR_CLK),
    .rst_i (wr_rst),
    .d_i   (rd_tog_q),
    .q_o   (rd_tog_in_wr)
  );

  sync_2ff #(.W(NUM_BANKS)) u_wr2rd_tog_sync (
    .clk_i (RD_CLK),
    .rst_i (rd_rst),
    .d_i   (wr_tog_q),
    .q_o   (wr_tog_in_rd)
  );

  // ------------------------------------------------------------------
  // Write side
  // ------------------------------------------------------------------
  logic [ADDR_W:0]       wr_ptr_q;
  logic [ADDR_W:0]       wr_ptr_d;
  logic                  wr_bank_q;
  logic                  wr_bank_d;
  logic                  row_ok_q;
  logic                  row_ok_d;
  logic                  wr_drop_q;
  logic                  wr_drop_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q;
  logic [DROP_CNT_W-1:0] drop_cnt_d;
  logic                  overrun_q;
  logic                  overrun_d;

  logic [NUM_BANKS-1:0]  full_wr;
  logic [ADDR_W:0]       eff_ptr;
  logic                  eff_ok;
  logic [CH_W-1:0]       wr_ch;
  logic [DATA_W-1:0]     chan_data;

  logic                  ram_we;
  logic [ADDR_W:0]       ram_waddr;
  logic [DATA_W-1:0]     ram_wdata;

  assign full_wr = banks_full(wr_tog_q, rd_tog_in_wr);

  // A row start in the same cycle as a pixel takes effect first, so the
  // pixel lands as pixel 0 of the new row.
  assign eff_ptr = bus.wr_line_start ? '0 : wr_ptr_q;
  assign eff_ok  = bus.wr_line_start ? ~full_wr[wr_bank_q] : row_ok_q;
  assign wr_ch   = CH_W'(eff_ptr % N_CH);

  // Select the ADC channel that owns the current pixel.
  always_comb begin
    chan_data = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (int'(wr_ch) == c) begin
        chan_data = bus.wr_data[c*DATA_W +: DATA_W];
      end
    end
  end

  // Write-side next state: row start/drop, pixel store, bank handover.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    wr_bank_d  = wr_bank_q;
    row_ok_d   = row_ok_q;
    wr_tog_d   = wr_tog_q;
    wr_drop_d  = 1'b0;
    drop_cnt_d = drop_cnt_q;
    overrun_d  = overrun_q;
    ram_we     = 1'b0;
    ram_waddr  = {wr_bank_q, eff_ptr[ADDR_W-1:0]};
    ram_wdata  = chan_data;

    if (bus.wr_line_start) begin
      // Restart the row; a partial row in progress is simply abandoned.
      wr_ptr_d = '0;
      row_ok_d = ~full_wr[wr_bank_q];
      if (full_wr[wr_bank_q]) begin
        wr_drop_d = 1'b1;
        if (drop_cnt_q != {DROP_CNT_W{1'b1}}) begin
          drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
        end
      end
    end

    if (bus.wr_valid) begin
      if (eff_ok && (eff_ptr < WPTR_END)) begin
        ram_we   = 1'b1;
        wr_ptr_d = eff_ptr + (ADDR_W + 1)'(1);
        if (eff_ptr == WPTR_LAST) begin
          // Row complete: publish the bank and move to the other one.
          wr_tog_d[wr_bank_q] = ~wr_tog_q[wr_bank_q];
          wr_bank_d           = ~wr_bank_q;
          row_ok_d            = 1'b0;
        end
      end else if (eff_ptr == WPTR_END) begin
        overrun_d = 1'b1;
      end
    end
  end

  // Write-side state registers.
  always_ff @(posedge WR_CLK or posedge wr_rst) begin
    if (wr_rst) begin
      wr_ptr_q   <= '0;
      wr_bank_q  <= 1'b0;
      row_ok_q   <= 1'b0;
      wr_tog_q   <= '0;
      wr_drop_q  <= 1'b0;
      drop_cnt_q <= '0;
      overrun_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      wr_bank_q  <= wr_bank_d;
      row_ok_q   <= row_ok_d;
      wr_tog_q   <= wr_tog_d;
      wr_drop_q  <= wr_drop_d;
      drop_cnt_q <= drop_cnt_d;
      overrun_q  <= overrun_d;
    end
  end

  assign bus.wr_drop     = wr_drop_q;
  assign bus.wr_drop_cnt = drop_cnt_q;
  assign bus.wr_overrun  = overrun_q;

  // ------------------------------------------------------------------
  // Bank storage: simple dual-port RAM, written on WR_CLK, read on RD_CLK
  // ------------------------------------------------------------------
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              ram_re;
  logic [ADDR_W:0]   ram_raddr;
  logic [DATA_W-1:0] ram_rdata_q;

  // Write port.
  always_ff @(posedge WR_CLK) begin
    if (ram_we) begin
      mem_q[ram_waddr] <= ram_wdata;
    end
  end

  // Registered read port.
  always_ff @(posedge RD_CLK) begin
    if (ram_re) begin
      ram_rdata_q <= mem_q[ram_raddr];
    end
  end

  // ------------------------------------------------------------------
  // Read side
  // ------------------------------------------------------------------
  logic [ADDR_W-1:0]    rd_ptr_q;
  logic [ADDR_W-1:0]    rd_ptr_d;
  logic                 rd_bank_q;
  logic                 rd_bank_d;
  logic                 rd_valid_q;
  logic                 rd_valid_d;
  logic                 rd_first_q;
  logic                 rd_first_d;
  logic                 rd_last_q;
  logic                 rd_last_d;
  logic [NUM_BANKS-1:0] full_rd;

  assign full_rd = banks_full(wr_tog_in_rd, rd_tog_q);

  // Read-side next state: accept a request only from a full bank.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    rd_bank_d  = rd_bank_q;
    rd_tog_d   = rd_tog_q;
    rd_valid_d = 1'b0;
    rd_first_d = 1'b0;
    rd_last_d  = 1'b0;
    ram_re     = 1'b0;
    ram_raddr  = {rd_bank_q, rd_ptr_q};

    if (bus.rd_en && full_rd[rd_bank_q]) begin
      ram_re     = 1'b1;
      rd_valid_d = 1'b1;
      rd_first_d = (rd_ptr_q == '0);
      rd_last_d  = (rd_ptr_q == RPTR_LAST);
      if (rd_ptr_q == RPTR_LAST) begin
        // Row drained: hand the bank back and move to the other one.
        rd_ptr_d            = '0;
        rd_tog_d[rd_bank_q] = ~rd_tog_q[rd_bank_q];
        rd_bank_d           = ~rd_bank_q;
      end else begin
        rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      end
    end
  end

  // Read-side state registers.
  always_ff @(posedge RD_CLK or posedge rd_rst) begin
    if (rd_rst) begin
      rd_ptr_q   <= '0;
      rd_bank_q  <= 1'b0;
      rd_tog_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_first_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      rd_bank_q  <= rd_bank_d;
      rd_tog_q   <= rd_tog_d;
      rd_valid_q <= rd_valid_d;
      rd_first_q <= rd_first_d;
      rd_last_q  <= rd_last_d;
    end
  end

  // The RAM output register has no reset; gate it so rd_data reads zero
  // whenever no pixel is being presented.
  assign bus.rd_data        = rd_valid_q ? ram_rdata_q : '0;
  assign bus.rd_valid       = rd_valid_q;
  assign bus.rd_first       = rd_first_q;
  assign bus.rd_last        = rd_last_q;
  assign bus.rd_lines_avail = {1'b0, full_rd[0]} + {1'b0, full_rd[1]};

endmodule : pingpong_line_buffer

// File: tb/tb_pingpong_line_buffer.sv
// Testbench for pingpong_line_buffer: short 8-pixel rows, two channels,
// 40 MHz write clock and 33 MHz read clock.
`timescale 1ns/1ps
module tb_pingpong_line_buffer;

  localparam int DATA_W = 14;
  localparam int PIX    = 8;
  localparam int N_CH   = 2;
  localparam int ADDR_W = 3;
  localparam int W      = DATA_W + 2;  // {first, last, data}

  // ---------------- clock / reset ----------------
  logic WR_CLK = 1'b0;
  logic RD_CLK = 1'b0;
  logic RESET  = 1'b1;

  always #12.5 WR_CLK = ~WR_CLK;
  always #15   RD_CLK = ~RD_CLK;

  pingpong_line_buffer_if #(.DATA_W(DATA_W), .N_CH(N_CH)) bus ();

  pingpong_line_buffer #(
    .DATA_W      (DATA_W),
    .PIX_PER_ROW (PIX),
    .N_CH        (N_CH),
    .ADDR_W      (ADDR_W)
  ) dut (
    .WR_CLK (WR_CLK),
    .RD_CLK (RD_CLK),
    .RESET  (RESET),
    .bus    (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int n_checks    = 0;
  int n_errors    = 0;
  int drop_pulses = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] pix(input int r, input int k, input int c);
    return DATA_W'(((r % 16) << 10) | ((c + 1) << 8) | (k & 8'hFF));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_wr(input int n);
    repeat (n) begin
      @(negedge WR_CLK);
      bus.wr_line_start = 1'b0;
      bus.wr_valid      = 1'b0;
    end
  endtask

  task automatic idle_rd(input int n);
    repeat (n) @(negedge RD_CLK);
  endtask

  // Row r, npix pixels, start coincident with pixel 0. Accepted rows push
  // their first PIX pixels (channel k mod N_CH) onto the scoreboard.
  task automatic write_row(input int r, input int npix, input bit push, input bit gaps);
    logic [N_CH*DATA_W-1:0] wd;
    for (int k = 0; k < npix; k++) begin
      if (gaps && k > 0 && $urandom_range(0, 3) == 0) begin
        @(negedge WR_CLK);
        bus.wr_line_start = 1'b0;
        bus.wr_valid      = 1'b0;
        bus.wr_data       = (N_CH*DATA_W)'({$urandom, $urandom});
      end
      for (int c = 0; c < N_CH; c++) wd[c*DATA_W +: DATA_W] = pix(r, k, c);
      @(negedge WR_CLK);
      bus.wr_line_start = (k == 0);
      bus.wr_valid      = 1'b1;
      bus.wr_data       = wd;
      if (push && k < PIX) exp_q.push_back({(k == 0), (k == PIX - 1), pix(r, k, k % N_CH)});
    end
    idle_wr(1);
  endtask

  task automatic wait_avail(input logic [1:0] n, input string tag);
    int i = 0;
    @(negedge RD_CLK);
    while (bus.rd_lines_avail != n && i < 50) begin
      @(negedge RD_CLK);
      i++;
    end
    check(tag, 32'(bus.rd_lines_avail), 32'(n));
  endtask

  task automatic drain(input string tag);
    int i = 0;
    @(negedge RD_CLK);
    bus.rd_en = 1'b1;
    while (exp_q.size() != 0 && i < 400) begin
      @(negedge RD_CLK);
      i++;
    end
    bus.rd_en = 1'b0;
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_rd_valid"}, 32'(bus.rd_valid), 32'd0);
    check({pfx, "_rd_data"},  32'(bus.rd_data), 32'd0);
    check({pfx, "_rd_first"}, 32'(bus.rd_first), 32'd0);
    check({pfx, "_rd_last"},  32'(bus.rd_last), 32'd0);
    check({pfx, "_avail"},    32'(bus.rd_lines_avail), 32'd0);
    check({pfx, "_drop"},     32'(bus.wr_drop), 32'd0);
    check({pfx, "_drop_cnt"}, 32'(bus.wr_drop_cnt), 32'd0);
    check({pfx, "_overrun"},  32'(bus.wr_overrun), 32'd0);
  endtask

  // ---------------- monitors ----------------
  initial begin : rd_monitor
    logic [W-1:0] e;
    forever begin
      @(posedge RD_CLK);
      #1;
      if (bus.rd_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("rd_unexpected_valid", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rd_data",  32'(bus.rd_data), 32'(e[DATA_W-1:0]));
          check("rd_first", 32'(bus.rd_first), 32'(e[W-1]));
          check("rd_last",  32'(bus.rd_last), 32'(e[W-2]));
        end
      end
    end
  end

  initial begin : drop_monitor
    forever begin
      @(posedge WR_CLK);
      #1;
      if (bus.wr_drop === 1'b1) drop_pulses++;
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int base;
    int i;
    bus.wr_line_start = 1'b0;
    bus.wr_valid      = 1'b0;
    bus.wr_data       = '0;
    bus.rd_en         = 1'b0;

    repeat (3) @(negedge WR_CLK);
    check_reset_outputs("rst");
    @(negedge WR_CLK);
    RESET = 1'b0;
    idle_wr(4);
    idle_rd(4);

    // Pixels without any row start are ignored.
    repeat (4) begin
      @(negedge WR_CLK);
      bus.wr_valid = 1'b1;
      bus.wr_data  = (N_CH*DATA_W)'({$urandom, $urandom});
    end
    idle_wr(1);
    idle_rd(8);
    check("stray_avail", 32'(bus.rd_lines_avail), 32'd0);
    check("stray_overrun", 32'(bus.wr_overrun), 32'd0);

    // Reads from an empty buffer produce nothing.
    @(negedge RD_CLK);
    bus.rd_en = 1'b1;
    repeat (4) begin
      @(negedge RD_CLK);
      check("empty_rd_valid", 32'(bus.rd_valid), 32'd0);
    end
    bus.rd_en = 1'b0;

    // Single row.
    write_row(0, PIX, 1'b1, 1'b0);
    wait_avail(2'd1, "t1_avail_1");
    drain("t1_drain");
    idle_rd(2);
    check("t1_avail_0", 32'(bus.rd_lines_avail), 32'd0);

    // Three rows, no reader: third is dropped.
    idle_wr(6);
    base = drop_pulses;
    check("t2_drop_cnt_0", 32'(bus.wr_drop_cnt), 32'd0);
    write_row(1, PIX, 1'b1, 1'b1);
    write_row(2, PIX, 1'b1, 1'b0);
    write_row(3, PIX, 1'b0, 1'b0);
    idle_wr(2);
    check("t2_drop_pulses", 32'(drop_pulses - base), 32'd1);
    check("t2_drop_cnt_1", 32'(bus.wr_drop_cnt), 32'd1);
    wait_avail(2'd2, "t2_avail_2");
    drain("t2_drain");
    idle_rd(2);
    check("t2_avail_0", 32'(bus.rd_lines_avail), 32'd0);

    // Nine pixels in an eight-pixel row.
    idle_wr(6);
    check("t3_overrun_0", 32'(bus.wr_overrun), 32'd0);
    write_row(4, PIX + 1, 1'b1, 1'b0);
    check("t3_overrun_1", 32'(bus.wr_overrun), 32'd1);
    write_row(5, PIX, 1'b1, 1'b0);
    wait_avail(2'd2, "t3_avail_2");
    drain("t3_drain");
    check("t3_overrun_sticky", 32'(bus.wr_overrun), 32'd1);

    // Abandoned partial row followed by a full row.
    idle_wr(6);
    write_row(6, 3, 1'b0, 1'b0);
    write_row(7, PIX, 1'b1, 1'b0);
    idle_rd(10);
    check("t4_avail_1", 32'(bus.rd_lines_avail), 32'd1);
    drain("t4_drain");

    // 100 rows against a continuous reader.
    idle_wr(6);
    base = drop_pulses;
    @(negedge RD_CLK);
    bus.rd_en = 1'b1;
    for (int r = 0; r < 100; r++) begin
      write_row(8 + r, PIX, 1'b1, 1'b1);
      idle_wr(5);
    end
    i = 0;
    while (exp_q.size() != 0 && i < 400) begin
      @(negedge RD_CLK);
      i++;
    end
    bus.rd_en = 1'b0;
    check("t5_drain", 32'(exp_q.size()), 32'd0);
    check("t5_no_drop", 32'(drop_pulses - base), 32'd0);
    check("t5_drop_cnt", 32'(bus.wr_drop_cnt), 32'd1);

    // Reset in the middle of a read.
    idle_wr(6);
    write_row(120, PIX, 1'b1, 1'b0);
    wait_avail(2'd1, "t6_avail_1");
    @(negedge RD_CLK);
    bus.rd_en = 1'b1;
    i = 0;
    while (exp_q.size() > 5 && i < 50) begin
      @(negedge RD_CLK);
      i++;
    end
    check("t6_mid_read", 32'(exp_q.size() <= 5), 32'd1);
    #3;
    RESET = 1'b1;
    #1;
    check_reset_outputs("t6_async");
    exp_q.delete();
    bus.rd_en = 1'b0;
    repeat (3) @(negedge WR_CLK);
    RESET = 1'b0;
    idle_wr(4);
    idle_rd(4);
    check("t6_avail_after_rst", 32'(bus.rd_lines_avail), 32'd0);
    write_row(121, PIX, 1'b1, 1'b1);
    wait_avail(2'd1, "t6_avail_new");
    drain("t6_drain");
    idle_rd(2);
    check("t6_avail_0", 32'(bus.rd_lines_avail), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_pingpong_line_buffer

// File: doc/pingpong_line_buffer.md
Name: pingpong_line_buffer

Overview:
Dual-clock, two-bank (ping-pong) line buffer for the thermal sensor readout path. It accepts one row of pixels from N_CH interleaved ADC channels in the ADC clock domain and streams completed rows to the frame/transmit logic in the read clock domain. Bank ownership is handed over automatically through synchronised toggle flags, so no external bank-select signal is needed. Rows that arrive while both banks are occupied are dropped and counted.

Parameters:
DATA_W, 14, pixel/ADC sample width
PIX_PER_ROW, 640, pixels per row; must be a multiple of N_CH
N_CH, 2, interleaved ADC channels; pixel k takes channel k mod N_CH
ADDR_W, 10, pixel address width; 2**ADDR_W >= PIX_PER_ROW

Ports:
WR_CLK  in  1  ADC-domain clock, rising edge
RD_CLK  in  1  read-domain clock, rising edge
RESET  in  1  asynchronous, active-high reset, applied to both domains
wr_line_start  in  1  WR_CLK; start of row; clears write pointer
wr_valid  in  1  WR_CLK; one pixel is present this cycle
wr_data  in  N_CH*DATA_W  WR_CLK; channel c occupies bits [c*DATA_W +: DATA_W]
wr_drop  out  1  WR_CLK; one-cycle pulse when a row is rejected
wr_drop_cnt  out  8  WR_CLK; saturating count of dropped rows
wr_overrun  out  1  WR_CLK; sticky flag: more than PIX_PER_ROW pixels were received in one row
rd_en  in  1  RD_CLK; request the next pixel
rd_valid  out  1  RD_CLK; rd_data is valid
rd_data  out  DATA_W  RD_CLK; pixel
rd_first  out  1  RD_CLK; qualifies pixel 0 of a row
rd_last  out  1  RD_CLK; qualifies pixel PIX_PER_ROW-1
rd_lines_avail  out  2  RD_CLK; number of completed, unread rows (0..2)

Behaviour:
- Reset (async): both pointers = 0; both banks = write bank 0, read bank 0; all toggles = 0. Outputs: wr_drop = 0, wr_drop_cnt = 0, wr_overrun = 0, rd_valid = 0, rd_data = 0, rd_first = 0, rd_last = 0, rd_lines_avail = 0. The reset is synchronised on deassertion separately in each domain.
- Bank state: bank b is full when wr_tog[b] != rd_tog[b].
  - The write side uses rd_tog passed through a 2-flop synchroniser.
  - The read side uses wr_tog passed through a 2-flop synchroniser.
- Write side, at wr_line_start:
  - wr_ptr = 0 and row_ok = not full(wr_bank).
  - If the bank is full: pulse wr_drop, increment wr_drop_cnt (saturates at 255), and ignore the whole row.
  - wr_line_start in mid-row discards the partial row; no toggle occurs.
- Write side, at wr_valid with row_ok and wr_ptr < PIX_PER_ROW:
  - Write channel (wr_ptr mod N_CH) to bank[wr_bank][wr_ptr], then wr_ptr++.
  - When the write hits PIX_PER_ROW-1: flip wr_tog[wr_bank], set wr_bank ^= 1, clear row_ok.
- Write side, at wr_valid with wr_ptr == PIX_PER_ROW: set wr_overrun; the data is ignored.
- wr_valid before any wr_line_start after reset is ignored.
- Simultaneous wr_line_start and wr_valid: start takes effect first, and the pixel is written as pixel 0.
- Read side, at rd_en with full(rd_bank):
  - Read bank[rd_bank][rd_ptr]; rd_valid rises 1 RD_CLK later, with rd_first/rd_last aligned to it.
  - rd_ptr++.
  - After reading PIX_PER_ROW-1: rd_ptr = 0, flip rd_tog[rd_bank], set rd_bank ^= 1.
- Read side, at rd_en while the bank is empty: no read; rd_valid = 0 next cycle (no underflow side effects).
- rd_lines_avail = number of banks that are full, as seen in the read domain.
- Visibility latency:
  - A completed row becomes readable no later than 3 RD_CLK edges after its wr_tog flip.
  - A freed bank becomes writable no later than 3 WR_CLK edges after its rd_tog flip.
- Bank order: banks alternate strictly 0,1,0,1 on both sides, so rows are never reordered.
- RESET mid-row or mid-read: in-flight data is lost and both sides return to bank 0, empty.

Decomposition:
- Shared package/define file: DATA_W, PIX_PER_ROW, N_CH, ADDR_W defaults, and a derived constant LAST_PIX = PIX_PER_ROW-1.
- Sub-module sync_2ff (parameterised-width 2-flop synchroniser with async reset), instantiated once per direction for the toggle vectors.
- Bank storage is inferred as a single simple dual-port RAM of 2*PIX_PER_ROW words, with address {bank, ptr}.

Test Plan:
- Single row, N_CH=2, PIX_PER_ROW=8, ch0 = 0x100+k and ch1 = 0x200+k -> reader gets 0x100,0x201,0x102,...,0x207; rd_first on word 0, rd_last on word 7; rd_lines_avail goes 1 -> 0.
- Three rows written back-to-back with rd_en held low -> rows 0 and 1 stored, row 2 produces one wr_drop pulse and wr_drop_cnt = 1; then reading returns rows 0 and 1 in order.
- Nine wr_valid pixels in an 8-pixel row -> wr_overrun = 1; the row stored is pixels 0..7; the next row is unaffected.
- wr_line_start after 3 pixels, then a full row -> reader sees only the full row; rd_lines_avail = 1.
- WR_CLK = 40 MHz, RD_CLK = 33 MHz, 100 rows with a continuous reader -> zero drops and data identical to a golden sequence.
- RESET asserted mid-read -> all outputs return to reset values asynchronously; a new row after reset is read correctly from bank 0.
